pipe_bundle_reg: RTL

- Parametrised successor to the single-entry enable flop used between decode, rename and the later stages.
- Registers an N-lane instruction bundle (per-lane valid plus payload) with a valid/ready handshake.
- A 2-entry skid store gives full throughput with a registered in_ready.
- Synchronous flush drops the whole bundle on branch-mispredict recovery.
- Instantiated at the decode/rename, rename/dispatch and EX/WB boundaries.

---
 rtl/pipe_bundle_reg_if.sv | 30 +++
 rtl/pipe_bundle_reg.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/pipe_bundle_reg_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_bundle_reg_if
// Brief    : Bundle handshake bus between pipeline stages.
//            master = producer/consumer side, slave = pipe_bundle_reg.
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_bundle_reg_if #(
    parameter int LANES = 2,
    parameter int WIDTH = 165
);
    logic [LANES-1:0]       in_valid;
    logic [LANES*WIDTH-1:0] in_data;
    logic                   in_ready;
    logic [LANES-1:0]       out_valid;
    logic [LANES*WIDTH-1:0] out_data;
    logic                   out_ready;
    logic [1:0]             occupancy;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );
endinterface
`default_nettype wire

// File: rtl/pipe_bundle_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_bundle_reg
// Brief    : N-lane bundle pipeline register with 2-entry skid store,
//            registered in_ready and synchronous flush.
//            Optional PIPE_BUNDLE_COMPACT_EN packs valid lanes toward lane 0.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_bundle_reg #(
    parameter int LANES = 2,
    parameter int WIDTH = 165
) (
    input  wire logic          clk,
    input  wire logic          reset,
    input  wire logic          flush,
    pipe_bundle_reg_if.slave   bus
);
    localparam int c_BITS = LANES * WIDTH;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_in_ready;
    logic [LANES-1:0]    r_main_valid;
    logic [c_BITS-1:0]   r_main_data;
    logic [LANES-1:0]    r_skid_valid;
    logic [c_BITS-1:0]   r_skid_data;

    logic                w_in_fire;
    logic                w_out_fire;
    logic                w_load_main_in;
    logic                w_load_main_skid;
    logic                w_load_skid;
    logic [LANES-1:0]    w_wr_valid;
    logic [c_BITS-1:0]   w_wr_data;

    assign w_in_fire  = (|bus.in_valid) & r_in_ready;
    assign w_out_fire = (|bus.out_valid) & bus.out_ready;

`ifdef PIPE_BUNDLE_COMPACT_EN
    // Each valid lane lands at the slot equal to the number of valid lanes
    // below it; unused upper slots are written as zero.
    always_comb begin : p_compact
        int cnt;
        cnt        = 0;
        w_wr_valid = '0;
        w_wr_data  = '0;
        for (int i = 0; i < LANES; i++) begin
            for (int j = 0; j < LANES; j++) begin
                if (bus.in_valid[i] && (cnt == j)) begin
                    w_wr_valid[j]                 = 1'b1;
                    w_wr_data[j*WIDTH +: WIDTH]   = bus.in_data[i*WIDTH +: WIDTH];
                end
            end
            if (bus.in_valid[i]) begin
                cnt = cnt + 1;
            end
        end
    end
`else
    assign w_wr_valid = bus.in_valid;
    assign w_wr_data  = bus.in_data;
`endif

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next           = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_fire) begin
                    w_load_main_in = 1'b1;
                    w_next         = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_in_fire && w_out_fire) begin
                    w_load_main_in = 1'b1;
                end else if (w_in_fire) begin
                    w_load_skid = 1'b1;
                    w_next      = ST_TWO;
                end else if (w_out_fire) begin
                    w_next = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (w_out_fire) begin
                    w_load_main_skid = 1'b1;
                    w_next           = ST_ONE;
                end
            end
            default: w_next = ST_EMPTY;
        endcase
    end

    // Flush kills only the valid bits; stale data stays hidden behind them.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_ready   <= 1'b1;
            r_main_valid <= '0;
            r_main_data  <= '0;
            r_skid_valid <= '0;
            r_skid_data  <= '0;
        end else if (flush) begin
            r_in_ready   <= 1'b1;
            r_main_valid <= '0;
            r_skid_valid <= '0;
        end else begin
            r_in_ready <= (w_next != ST_TWO);
            if (w_load_main_in) begin
                r_main_valid <= w_wr_valid;
                r_main_data  <= w_wr_data;
            end else if (w_load_main_skid) begin
                r_main_valid <= r_skid_valid;
                r_main_data  <= r_skid_data;
            end
            if (w_load_skid) begin
                r_skid_valid <= w_wr_valid;
                r_skid_data  <= w_wr_data;
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = (r_state != ST_EMPTY) ? r_main_valid : '0;
    assign bus.out_data  = r_main_data;
    assign bus.occupancy = r_state;

endmodule
`default_nettype wire
